// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [31:0] UART_TXDATA_ADDR = 32'hffff_0020;
  localparam logic [31:0] UART_STATUS_ADDR = 32'hffff_0024;
  localparam logic [31:0] UART_CTRL_ADDR   = 32'hffff_0028;

  localparam int unsigned STATUS_NOT_FULL_BIT  = 0;
  localparam int unsigned STATUS_BUSY_BIT      = 1;
  localparam int unsigned STATUS_PEND_BIT      = 2;
  localparam int unsigned STATUS_OVF_BIT       = 3;
  localparam int unsigned STATUS_COUNT_LSB     = 4;
  localparam int unsigned STATUS_PARITY_BIT    = 8;

  localparam int unsigned CTRL_IE_BIT       = 0;
  localparam int unsigned CTRL_CLR_PEND_BIT = 1;
  localparam int unsigned CTRL_CLR_OVF_BIT  = 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push while full is dropped even if a pop shares the edge.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrW'(1);
      if (do_pop)  rd_q <= rd_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO serial transmitter: address decode, CTRL/STATUS, FIFO and 8-N-1 shifter.
// Define UART_TX_PARITY_EN to add an even-parity bit before the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        UartInterrupt,
  output logic [31:0] cycle_out,
  output logic        UartAddress,
  output logic        tx,
  input  logic [31:0] data,
  input  logic [31:0] address,
  input  logic        MemRead,
  input  logic        MemWrite
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic        ParityAdv = 1'b1;
  localparam uart_state_e AfterData = StParity;
`else
  localparam logic        ParityAdv = 1'b0;
  localparam uart_state_e AfterData = StStop;
`endif

  logic sel_txdata, sel_status, sel_ctrl, wr_txdata, wr_ctrl;
  logic fifo_pop, fifo_full, fifo_empty, frame_done;
  logic [7:0]      fifo_dout;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     status, rdata;
  logic            ie_q, pend_q, ovf_q;
  logic            unused_data;

  uart_state_e      state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             baud_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign sel_txdata  = (address == UART_TXDATA_ADDR);
  assign sel_status  = (address == UART_STATUS_ADDR);
  assign sel_ctrl    = (address == UART_CTRL_ADDR);
  assign UartAddress = sel_txdata | sel_status | sel_ctrl;
  assign wr_txdata   = MemWrite & sel_txdata;
  assign wr_ctrl     = MemWrite & sel_ctrl;
  assign unused_data = ^data[31:8];

  uart_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_txdata),
    .pop  (fifo_pop),
    .din  (data[7:0]),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    status = '0;
    status[STATUS_NOT_FULL_BIT] = ~fifo_full;
    status[STATUS_BUSY_BIT]     = (state_q != StIdle);
    status[STATUS_PEND_BIT]     = pend_q;
    status[STATUS_OVF_BIT]      = ovf_q;
    status[STATUS_COUNT_LSB +: 4] = 4'(fifo_count);
    status[STATUS_PARITY_BIT]   = ParityAdv;
    rdata = '0;
    if (sel_status) rdata = status;
    if (sel_ctrl)   rdata[CTRL_IE_BIT] = ie_q;
  end

  assign cycle_out     = (MemRead & UartAddress) ? rdata : 'z;
  assign UartInterrupt = ie_q & pend_q;
  assign baud_end      = (baud_q == BaudW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q + BaudW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    fifo_pop   = 1'b0;
    frame_done = 1'b0;
    tx         = 1'b1;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          bit_d    = '0;
          state_d  = StStart;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_dout;
`endif
        end
      end
      StStart: begin
        tx = 1'b0;
        if (baud_end) begin
          baud_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        tx = shift_q[0];
        if (baud_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = AfterData;
        end
      end
      StParity: begin
`ifdef UART_TX_PARITY_EN
        tx = parity_q;
`endif
        if (baud_end) begin
          baud_d  = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d     = '0;
          state_d    = StIdle;
          frame_done = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // A clear of pend (CTRL or accepted TXDATA write) beats a same-edge set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ctrl) ie_q <= data[CTRL_IE_BIT];
      if ((wr_ctrl & data[CTRL_CLR_PEND_BIT]) | (wr_txdata & ~fifo_full)) pend_q <= 1'b0;
      else if (frame_done & fifo_empty) pend_q <= 1'b1;
      if (wr_ctrl & data[CTRL_CLR_OVF_BIT]) ovf_q <= 1'b0;
      else if (wr_txdata & fifo_full)       ovf_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TXDATA = 32'hffff_0020;
  localparam logic [31:0] A_STATUS = 32'hffff_0024;
  localparam logic [31:0] A_CTRL   = 32'hffff_0028;
`ifdef UART_TX_PARITY_EN
  localparam int   FRAME_END = 45;
  localparam logic PAR_ADV   = 1'b1;
`else
  localparam int   FRAME_END = 41;
  localparam logic PAR_ADV   = 1'b0;
`endif

  logic        clk, reset, MemRead, MemWrite;
  logic [31:0] data, address;
  logic        UartInterrupt, UartAddress, tx;
  logic [31:0] cycle_out;
  int          errors = 0;
  int          checks = 0;

  mmio_uart_tx #(
    .CLKS_PER_BIT(4),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .UartInterrupt(UartInterrupt),
    .cycle_out    (cycle_out),
    .UartAddress  (UartAddress),
    .tx           (tx),
    .data         (data),
    .address      (address),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level after edge n, for a byte accepted at edge 0 into an idle block.
  function automatic logic exp_tx(input logic [7:0] b, input int n);
    if (n <= 4) return 1'b0;
    if (n <= 36) return b[(n - 5) / 4];
`ifdef UART_TX_PARITY_EN
    if (n <= 40) return ^b;
`endif
    return 1'b1;
  endfunction

  // Single store; returns at the falling edge just after the write edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address  = a;
    data     = d;
    MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; address = '0; data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (UartInterrupt !== 1'b0) begin
      errors++; $display("FAIL reset_int got=%b exp=0", UartInterrupt);
    end
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h01}) begin
      errors++; $display("FAIL reset_status got=%h exp=%h", cycle_out, {23'b0, PAR_ADV, 8'h01});
    end
    checks++; if (UartAddress !== 1'b1) begin
      errors++; $display("FAIL status_addr_hit got=%b exp=1", UartAddress);
    end
    address = A_TXDATA; #1;
    checks++; if (cycle_out !== 32'h0) begin
      errors++; $display("FAIL txdata_read got=%h exp=0", cycle_out);
    end
    address = 32'h1001_0000; #1;
    checks++; if (UartAddress !== 1'b0) begin
      errors++; $display("FAIL mem_addr_miss got=%b exp=0", UartAddress);
    end
    MemRead = 1'b0;
  endtask

  task automatic test_frame(input logic [7:0] b);
    bus_write(A_TXDATA, {24'b0, b});
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h11}) begin
      errors++; $display("FAIL status_after_write got=%h exp=%h", cycle_out,
                         {23'b0, PAR_ADV, 8'h11});
    end
    for (int n = 1; n <= FRAME_END + 2; n++) begin
      @(negedge clk);
      checks++; if (tx !== exp_tx(b, n)) begin
        errors++; $display("FAIL frame_tx byte=%h edge=%0d got=%b exp=%b", b, n, tx, exp_tx(b, n));
      end
      checks++; if (cycle_out[1] !== (n < FRAME_END)) begin
        errors++; $display("FAIL frame_busy edge=%0d got=%b exp=%b", n, cycle_out[1],
                           (n < FRAME_END));
      end
    end
    MemRead = 1'b0;
  endtask

  task automatic test_interrupt;
    bus_write(A_CTRL, 32'h1);
    #1;
    checks++; if (UartInterrupt !== 1'b1) begin
      errors++; $display("FAIL int_stale_pend got=%b exp=1", UartInterrupt);
    end
    bus_write(A_TXDATA, 32'hA3);
    #1;
    checks++; if (UartInterrupt !== 1'b0) begin
      errors++; $display("FAIL int_cleared_by_write got=%b exp=0", UartInterrupt);
    end
    repeat (FRAME_END - 1) @(negedge clk);
    checks++; if (UartInterrupt !== 1'b0) begin
      errors++; $display("FAIL int_before_end got=%b exp=0", UartInterrupt);
    end
    @(negedge clk);
    checks++; if (UartInterrupt !== 1'b1) begin
      errors++; $display("FAIL int_at_end got=%b exp=1", UartInterrupt);
    end
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h05}) begin
      errors++; $display("FAIL status_pend got=%h exp=%h", cycle_out, {23'b0, PAR_ADV, 8'h05});
    end
    MemRead = 1'b0;
    bus_write(A_CTRL, 32'h3);
    #1;
    checks++; if (UartInterrupt !== 1'b0) begin
      errors++; $display("FAIL int_ctrl_clear got=%b exp=0", UartInterrupt);
    end
    address = A_CTRL; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== 32'h1) begin
      errors++; $display("FAIL ctrl_ie_kept got=%h exp=1", cycle_out);
    end
    MemRead = 1'b0;
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    @(negedge clk);
    address = A_TXDATA; MemWrite = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = {24'b0, bytes[i]};
      @(negedge clk);
    end
    MemWrite = 1'b0;
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h4A}) begin
      errors++; $display("FAIL status_overflow got=%h exp=%h", cycle_out, {23'b0, PAR_ADV, 8'h4A});
    end
    MemRead = 1'b0;
    bus_write(A_CTRL, 32'h4);
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h42}) begin
      errors++; $display("FAIL status_ovf_clear got=%h exp=%h", cycle_out, {23'b0, PAR_ADV, 8'h42});
    end
    MemRead = 1'b0;
  endtask

  // Continues from test_overflow: byte 0x00 is in its data bits.
  task automatic test_reset_mid;
    repeat (4) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_mid_data got=%b exp=0", tx); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_after_reset got=%b exp=1", tx); end
    address = A_STATUS; MemRead = 1'b1; #1;
    checks++; if (cycle_out !== {23'b0, PAR_ADV, 8'h01}) begin
      errors++; $display("FAIL status_after_reset got=%h exp=%h", cycle_out,
                         {23'b0, PAR_ADV, 8'h01});
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      checks++; if (tx !== 1'b1 || UartInterrupt !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset cyc=%0d tx=%b int=%b exp tx=1 int=0", n, tx,
                           UartInterrupt);
      end
    end
    MemRead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame(8'h55);
    test_interrupt();
    test_overflow();
    test_reset_mid();
    test_frame(8'h07);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
